// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the streaming UART transmitter.
//               Build option UART_TX_PARITY_EN adds the PARITY state (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;
`endif

  // Clock cycles per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_stream_if
// Description : Valid/ready byte stream into the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_stream_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO with show-ahead read; DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 i_push,
  input  wire logic [DATA_BITS-1:0] i_data,
  input  wire logic                 i_pop,
  output logic      [DATA_BITS-1:0] o_data,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [c_AW:0]        r_wr_ptr;
  logic [c_AW:0]        r_rd_ptr;
  logic                 w_push;
  logic                 w_pop;

  // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
  end

  assign o_data = r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_stream
// Description : Buffered 8N1 UART transmitter with valid/ready byte input.
//               Define UART_TX_PARITY_EN for 8E1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  uart_tx_stream_if.slave s_in,
  output logic            txd,
  output logic            busy
);

  localparam int c_DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_BIT_W = $clog2(DATA_BITS);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);

  logic [1:0]           r_rst_sync;
  logic                 w_rst_n;

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [c_BIT_W-1:0]   r_bit;
  logic [c_BIT_W-1:0]   w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_txd;
  logic                 w_txd_nxt;
`ifdef UART_TX_PARITY_EN
  logic                 r_par;
  logic                 w_par_nxt;
`endif

  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_cnt_wrap;
  logic                 w_start;

  // Reset asserts asynchronously, releases two edges after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_push  (s_in.in_valid),
    .i_data  (s_in.in_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign s_in.in_ready = !w_full;
  assign w_cnt_wrap    = (r_cnt == c_CNT_LAST);
  assign w_start       = !w_empty &&
                         ((r_state == S_IDLE) || ((r_state == S_STOP) && w_cnt_wrap));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif

    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_cnt_wrap ? '0 : r_cnt + c_CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        w_cnt_nxt = '0;
      end
      S_START: begin
        if (w_cnt_wrap) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
          w_txd_nxt   = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_cnt_wrap) begin
          if (r_bit == c_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_txd_nxt   = r_par;
`else
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
`endif
          end else begin
            w_bit_nxt   = r_bit + c_BIT_W'(1);
            w_shift_nxt = r_shift >> 1;
            w_txd_nxt   = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_cnt_wrap) begin
          w_state_nxt = S_STOP;
          w_txd_nxt   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_cnt_wrap) begin
          w_state_nxt = S_IDLE;
          w_txd_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase

    // A new frame starts straight from IDLE or from the end of the stop bit.
    if (w_start) begin
      w_pop       = 1'b1;
      w_state_nxt = S_START;
      w_cnt_nxt   = '0;
      w_txd_nxt   = 1'b0;
      w_shift_nxt = w_fifo_data;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = ^w_fifo_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_txd   <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  assign txd  = r_txd;
  assign busy = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_stream
// Description : Self-checking bench for uart_tx_stream against a line-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stream;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int DEPTH    = 4;
  localparam int DIV      = ((CLK_FREQ * 2) / BAUD + 1) / 2;
`ifdef UART_TX_PARITY_EN
  localparam int FBITS    = 11;
`else
  localparam int FBITS    = 10;
`endif
  localparam int FRAME    = FBITS * DIV;

  logic clk = 1'b0;
  logic reset_n;
  logic txd;
  logic busy;

  always #5 clk = ~clk;

  uart_tx_stream_if u_if ();

  uart_tx_stream #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_in    (u_if),
    .txd     (txd),
    .busy    (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Line model: bytes waiting in the buffer, byte on the line, cycle offset in its frame.
  logic [7:0] mq[$];
  logic [7:0] m_cur = 8'h00;
  int         m_pos = -1;
  bit         m_acc = 1'b0;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic m_txd();
    return (m_pos < 0) ? 1'b1 : frame_bit(m_cur, m_pos / DIV);
  endfunction

  function automatic logic m_busy();
    return (m_pos >= 0) || (mq.size() > 0);
  endfunction

  function automatic logic m_ready();
    return mq.size() < DEPTH;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pos = -1;
    m_acc = 1'b0;
  endtask

  // Drive inputs at a falling edge, take one rising edge, return at the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] d);
    bit acc;
    u_if.in_valid = v;
    u_if.in_data  = d;
    acc = v && (mq.size() < DEPTH);
    @(posedge clk);
    if (m_pos >= 0) begin
      m_pos++;
      if (m_pos == FRAME) m_pos = -1;
    end
    if (m_pos < 0 && mq.size() > 0) begin
      m_cur = mq.pop_front();
      m_pos = 0;
    end
    if (acc) mq.push_back(d);
    m_acc = acc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd actual=%b required=1", txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy actual=%b required=0", busy); end
    total++; if (u_if.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready actual=%b required=1", u_if.in_ready); end
    reset_n = 1'b1;
    model_reset();
    repeat (4) cycle(1'b0, 8'h00);
    total++;
    if ({txd, busy, u_if.in_ready} !== 3'b101) begin
      bad++; $display("FAIL release_idle actual=%b required=101", {txd, busy, u_if.in_ready});
    end
  endtask

  task automatic test_single_55();
    int e_txd = 0, e_busy = 0, e_rdy = 0;
    int runs[10];
    int nrun;
    logic prev;
    foreach (runs[i]) runs[i] = 0;
    cycle(1'b1, 8'h55);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL s55_pre_start actual=%b required=1", txd); end
    cycle(1'b0, 8'h00);
    total++; if (txd !== 1'b0) begin bad++; $display("FAIL s55_latency actual=%b required=0", txd); end
    nrun = 0; runs[0] = 1; prev = txd;
    for (int k = 1; k < FRAME + 40; k++) begin
      cycle(1'b0, 8'h00);
      if (txd !== m_txd()) e_txd++;
      if (busy !== m_busy()) e_busy++;
      if (u_if.in_ready !== m_ready()) e_rdy++;
      if (txd === prev) begin
        if (nrun < 10) runs[nrun]++;
      end else begin
        nrun++;
        if (nrun < 10) runs[nrun] = 1;
        prev = txd;
      end
    end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (runs[i] !== DIV) begin bad++; $display("FAIL s55_level%0d_len actual=%0d required=%0d", i, runs[i], DIV); end
    end
    total++; if (nrun !== FBITS - 1) begin bad++; $display("FAIL s55_levels actual=%0d required=%0d", nrun + 1, FBITS); end
    total++; if (e_txd !== 0) begin bad++; $display("FAIL s55_txd mismatched_cycles=%0d required=0", e_txd); end
    total++; if (e_busy !== 0) begin bad++; $display("FAIL s55_busy mismatched_cycles=%0d required=0", e_busy); end
    total++; if (e_rdy !== 0) begin bad++; $display("FAIL s55_ready mismatched_cycles=%0d required=0", e_rdy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[7];
    int idx = 0, t = 0, guard = 0;
    int e_txd = 0, e_busy = 0, e_rdy = 0;
    foreach (b[i]) b[i] = 8'($urandom);
    while (idx < 7 && t < 10 * FRAME) begin
      cycle(1'b1, b[idx]);
      if (m_acc) idx++;
      t++;
      if (txd !== m_txd()) e_txd++;
      if (busy !== m_busy()) e_busy++;
      if (u_if.in_ready !== m_ready()) e_rdy++;
      if (t == 5) begin
        total++; if (u_if.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full_after5 actual=%b required=0", u_if.in_ready); end
      end
      if (t == FRAME + 1) begin
        total++; if (u_if.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_before_frame_end actual=%b required=0", u_if.in_ready); end
      end
      if (t == FRAME + 2) begin
        total++; if (u_if.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_frame_end actual=%b required=1", u_if.in_ready); end
      end
    end
    while (m_busy() && guard < 8 * FRAME) begin
      cycle(1'b0, 8'h00);
      guard++;
      if (txd !== m_txd()) e_txd++;
      if (busy !== m_busy()) e_busy++;
      if (u_if.in_ready !== m_ready()) e_rdy++;
    end
    total++; if (e_txd !== 0) begin bad++; $display("FAIL b2b_txd mismatched_cycles=%0d required=0", e_txd); end
    total++; if (e_busy !== 0) begin bad++; $display("FAIL b2b_busy mismatched_cycles=%0d required=0", e_busy); end
    total++; if (e_rdy !== 0) begin bad++; $display("FAIL b2b_ready mismatched_cycles=%0d required=0", e_rdy); end
  endtask

  task automatic test_reset_mid_frame();
    int e_txd = 0, e_low = 0, e_busy = 0;
    cycle(1'b1, 8'hA3);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom));
    for (int k = 0; k < 2000; k++) begin
      cycle(1'b0, 8'h00);
      if (txd !== m_txd()) e_txd++;
    end
    #2 reset_n = 1'b0;
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rmid_txd actual=%b required=1", txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy actual=%b required=0", busy); end
    total++; if (u_if.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready actual=%b required=1", u_if.in_ready); end
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < FRAME + 200; k++) begin
      cycle(1'b0, 8'h00);
      if (txd !== 1'b1) e_low++;
      if (busy !== 1'b0) e_busy++;
    end
    total++; if (e_txd !== 0) begin bad++; $display("FAIL rmid_pre_txd mismatched_cycles=%0d required=0", e_txd); end
    total++; if (e_low !== 0) begin bad++; $display("FAIL rmid_post_txd low_cycles=%0d required=0", e_low); end
    total++; if (e_busy !== 0) begin bad++; $display("FAIL rmid_post_busy busy_cycles=%0d required=0", e_busy); end
  endtask

  task automatic test_busy_ff();
    int t_low = -1, t_fall = -1, c0, e_high = 0;
    cycle(1'b1, 8'hFF);
    c0 = cyc;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ff_busy_on_accept actual=%b required=1", busy); end
    for (int k = 0; k < 2 * FRAME && t_fall < 0; k++) begin
      cycle(1'b0, 8'h00);
      if (t_low < 0 && txd === 1'b0) t_low = cyc;
      if (t_low >= 0 && t_fall < 0 && busy === 1'b0) t_fall = cyc;
    end
    total++; if (t_low - c0 !== 1) begin bad++; $display("FAIL ff_latency actual=%0d required=1", t_low - c0); end
    total++; if (t_fall - t_low !== FRAME) begin bad++; $display("FAIL ff_busy_fall actual=%0d required=%0d", t_fall - t_low, FRAME); end
    for (int k = 0; k < 300; k++) begin
      cycle(1'b0, 8'h00);
      if (txd !== 1'b1) e_high++;
    end
    total++; if (e_high !== 0) begin bad++; $display("FAIL ff_idle_txd low_cycles=%0d required=0", e_high); end
  endtask

  task automatic test_random_gaps();
    int e_txd = 0, e_busy = 0, e_rdy = 0, guard;
    for (int i = 0; i < 4; i++) begin
      int gap;
      logic [7:0] d;
      gap = $urandom_range(0, FRAME + 400);
      d   = 8'($urandom);
      repeat (gap) begin
        cycle(1'b0, 8'h00);
        if (txd !== m_txd()) e_txd++;
        if (busy !== m_busy()) e_busy++;
        if (u_if.in_ready !== m_ready()) e_rdy++;
      end
      guard = 0;
      do begin
        cycle(1'b1, d);
        guard++;
        if (txd !== m_txd()) e_txd++;
        if (busy !== m_busy()) e_busy++;
        if (u_if.in_ready !== m_ready()) e_rdy++;
      end while (!m_acc && guard < 3 * FRAME);
    end
    guard = 0;
    while (m_busy() && guard < 6 * FRAME) begin
      cycle(1'b0, 8'h00);
      guard++;
      if (txd !== m_txd()) e_txd++;
      if (busy !== m_busy()) e_busy++;
      if (u_if.in_ready !== m_ready()) e_rdy++;
    end
    total++; if (e_txd !== 0) begin bad++; $display("FAIL rnd_txd mismatched_cycles=%0d required=0", e_txd); end
    total++; if (e_busy !== 0) begin bad++; $display("FAIL rnd_busy mismatched_cycles=%0d required=0", e_busy); end
    total++; if (e_rdy !== 0) begin bad++; $display("FAIL rnd_ready mismatched_cycles=%0d required=0", e_rdy); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int c0, off, e_txd = 0;
    logic p0 = 1'bx, p1 = 1'bx;
    cycle(1'b1, 8'h07);
    c0 = cyc;
    cycle(1'b1, 8'h03);
    for (int k = 0; k < 2 * FRAME + 20; k++) begin
      cycle(1'b0, 8'h00);
      off = cyc - (c0 + 1);
      if (txd !== m_txd()) e_txd++;
      if (off == 9 * DIV + DIV / 2) p0 = txd;
      if (off == FRAME + 9 * DIV + DIV / 2) p1 = txd;
    end
    total++; if (p0 !== 1'b1) begin bad++; $display("FAIL par_07 actual=%b required=1", p0); end
    total++; if (p1 !== 1'b0) begin bad++; $display("FAIL par_03 actual=%b required=0", p1); end
    total++; if (e_txd !== 0) begin bad++; $display("FAIL par_txd mismatched_cycles=%0d required=0", e_txd); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_55();
    test_back_to_back();
    test_reset_mid_frame();
    test_busy_ff();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate; DIV = round(CLK_FREQ/BAUD) = 434 at defaults.
REQ-003 Parameter FIFO_DEPTH, default 4, byte buffer entries; power of two, minimum 2.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  8  byte to transmit.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block can accept a byte this cycle.
REQ-009 txd  output  1  serial line; idle high; drives the RXD pin of the soft-core UART (GPIO_0[0]).
REQ-010 busy  output  1  high while the FIFO is non-empty or a frame is on the line.

Function
REQ-011 A byte SHALL be accepted on any rising edge where in_valid and in_ready are both high; in_data is not sampled otherwise.
REQ-012 in_ready SHALL equal "FIFO not full"; it is combinational from FIFO state only, never from in_valid.
REQ-013 Frame format SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1; each bit held exactly DIV clock cycles.
REQ-014 Serializer states SHALL be IDLE, START, DATA, STOP (plus PARITY when enabled); IDLE->START on FIFO non-empty (pop same edge), START->DATA after DIV cycles, DATA->STOP after 8 bits, STOP->START if FIFO non-empty else IDLE.
REQ-015 Latency: a byte accepted at edge E into an empty, idle block SHALL drive txd low from edge E+1.
REQ-016 Back-to-back bytes SHALL be sent with no idle gap: next start bit begins immediately after DIV stop-bit cycles.
REQ-017 txd SHALL be driven from a flop (glitch-free); txd = 1 in IDLE.
REQ-018 Simultaneous push and pop on a full FIFO SHALL not occur (in_ready low); simultaneous push and pop on a non-full FIFO SHALL both take effect, occupancy unchanged.
REQ-019 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH with one extra bit for full/empty discrimination.
REQ-020 Baud counter SHALL count 0..DIV-1 and wrap; width = $clog2(DIV).
REQ-021 busy SHALL deassert on the edge the serializer returns to IDLE with FIFO empty.

Reset
REQ-022 Asserting reset_n low SHALL immediately set txd=1, busy=0, state=IDLE, FIFO empty, counters 0; in_ready=1.
REQ-023 Reset mid-frame SHALL abort the frame; the partial frame and all buffered bytes are discarded, no resumption after release.
REQ-024 Reset release SHALL be synchronized internally (async assert, sync deassert).

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: frame is 8E1, PARITY state between DATA and STOP sends even parity (XOR of 8 data bits), frame = 11*DIV cycles.
REQ-026 Macro undefined: no PARITY state or logic, frame = 10*DIV cycles.

Structure
REQ-027 Package uart_pkg SHALL hold the serializer state enum, DATA_BITS=8, and a function computing DIV from CLK_FREQ and BAUD.
REQ-028 FIFO SHALL be a separate sub-module uart_tx_fifo (parameter DEPTH, width 8, push/pop/full/empty).

Verification
REQ-029 Send 0x55 at defaults -> txd: 0,1,0,1,0,1,0,1,0,1, each level exactly 434 cycles, txd low at edge E+1.
REQ-030 Push 7 bytes with in_valid held high -> first 5 accepted (1 in serializer, 4 in FIFO), in_ready low until the first frame completes, all 7 bytes eventually sent in order, no inter-frame gap.
REQ-031 Reset_n pulsed low 2000 cycles into a 0xA3 frame with 3 bytes queued -> txd=1 same cycle, busy=0, nothing further transmitted after release.
REQ-032 UART_TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 4774 cycles.
REQ-033 Single byte 0xFF, then idle -> busy falls exactly 4340 cycles after txd first goes low; txd stays 1 thereafter.
